// File: rtl/store_buffer.sv
// In-order store buffer between the core write stage and data memory.
// Queues core stores in a circular FIFO, drains them over a valid/ready channel, and forwards buffered data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      dmem_addr,
    input  logic             write_enable,
    input  logic [31:0]      write_mem_data,
    output logic [31:0]      dmem_data,
    output logic [31:0]      mem_raddr,
    input  logic [31:0]      mem_rdata,
    output logic             mem_wvalid,
    input  logic             mem_wready,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic [PTR_W:0]   sb_count,
    output logic             sb_empty,
    output logic             sb_overflow
);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             full;
    logic             push;
    logic             pop;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign pop   = mem_wvalid && mem_wready;
    // A full buffer still accepts a store when the head drains on the same edge.
    assign push  = write_enable && (!full || pop);

    assign mem_wvalid  = (count != '0);
    assign mem_waddr   = addr_q[head];
    assign mem_wdata   = data_q[head];
    assign mem_raddr   = dmem_addr;
    assign sb_count    = count;
    assign sb_empty    = (count == '0);
    assign sb_overflow = overflow;

    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        dmem_data = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (addr_q[idx][31:2] == dmem_addr[31:2])) begin
                dmem_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            // When full with push and pop, tail == head and this set overrides the clear above.
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (write_enable && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= dmem_addr;
            data_q[tail] <= write_mem_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of expected memory writes plus per-scenario tasks.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      dmem_addr;
    logic             write_enable;
    logic [31:0]      write_mem_data;
    logic [31:0]      dmem_data;
    logic [31:0]      mem_raddr;
    logic [31:0]      mem_rdata;
    logic             mem_wvalid;
    logic             mem_wready;
    logic [31:0]      mem_waddr;
    logic [31:0]      mem_wdata;
    logic [PTR_W:0]   sb_count;
    logic             sb_empty;
    logic             sb_overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .dmem_addr(dmem_addr), .write_enable(write_enable),
        .write_mem_data(write_mem_data), .dmem_data(dmem_data), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .sb_count(sb_count),
        .sb_empty(sb_empty), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge, so mid-cycle shows what the next edge will transfer.
    always @(negedge clk) begin
        if (!reset && mem_wvalid && mem_wready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_waddr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             mem_waddr, mem_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dmem_addr      = a;
        write_mem_data = d;
        write_enable   = 1'b1;
        if (exp_q.size() < DEPTH || mem_wready) exp_q.push_back({a, d});
        cycle();
        write_enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        mem_wready = 1'b1;
        for (int k = 0; k < 20 && sb_empty !== 1'b1; k++) cycle();
        mem_wready = 1'b0;
        n_cmp++;
        if (sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_timeout: sb_empty=%b sb_count=%0d, required empty", sb_empty, sb_count);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_missing: %0d writes never emerged, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({sb_empty, sb_count, mem_wvalid, sb_overflow} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: empty=%b count=%0d wvalid=%b ovf=%b, required 1 0 0 0",
                     sb_empty, sb_count, mem_wvalid, sb_overflow);
        end
        mem_rdata = 32'hDEADBEEF;
        dmem_addr = 32'h0000_0100;
        #1;
        n_cmp++;
        if (dmem_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL reset_load: got %h, required deadbeef", dmem_data);
        end
        n_cmp++;
        if (mem_raddr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL raddr: got %h, required 00000100", mem_raddr);
        end
    endtask

    task automatic test_drain_order();
        mem_wready = 1'b0;
        store(32'h10, 32'h11111111);
        store(32'h20, 32'h22222222);
        n_cmp++;
        if (sb_count !== 3'd2 || mem_waddr !== 32'h10 || mem_wdata !== 32'h11111111) begin
            n_fail++;
            $display("FAIL two_stores: count=%0d waddr=%h wdata=%h, required 2 00000010 11111111",
                     sb_count, mem_waddr, mem_wdata);
        end
        cycle();
        n_cmp++;
        if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h10) begin
            n_fail++;
            $display("FAIL hold_stable: wvalid=%b waddr=%h, required 1 00000010", mem_wvalid, mem_waddr);
        end
        mem_wready = 1'b1;
        cycle();
        n_cmp++;
        if (sb_count !== 3'd1 || mem_waddr !== 32'h20) begin
            n_fail++;
            $display("FAIL first_drain: count=%0d waddr=%h, required 1 00000020", sb_count, mem_waddr);
        end
        cycle();
        mem_wready = 1'b0;
        n_cmp++;
        if (sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL second_drain: sb_empty=%b, required 1", sb_empty);
        end
    endtask

    task automatic test_bypass();
        mem_wready = 1'b0;
        store(32'h40, 32'h0000000A);
        store(32'h40, 32'h0000000B);
        dmem_addr = 32'h42;
        mem_rdata = 32'h0;
        #1;
        n_cmp++;
        if (dmem_data !== 32'h0000000B) begin
            n_fail++;
            $display("FAIL youngest_wins: got %h, required 0000000b", dmem_data);
        end
        dmem_addr = 32'h44;
        mem_rdata = 32'h5555AAAA;
        #1;
        n_cmp++;
        if (dmem_data !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL miss_load: got %h, required 5555aaaa", dmem_data);
        end
        // A store issued this cycle must not forward to a same-cycle load.
        dmem_addr      = 32'h48;
        write_mem_data = 32'h0000000C;
        write_enable   = 1'b1;
        exp_q.push_back({32'h48, 32'h0000000C});
        #1;
        n_cmp++;
        if (dmem_data !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL incoming_no_fwd: got %h, required 5555aaaa", dmem_data);
        end
        cycle();
        write_enable = 1'b0;
        #1;
        n_cmp++;
        if (dmem_data !== 32'h0000000C) begin
            n_fail++;
            $display("FAIL next_cycle_fwd: got %h, required 0000000c", dmem_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        mem_wready = 1'b0;
        for (int i = 0; i < 5; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        n_cmp++;
        if (sb_count !== 3'd4 || sb_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: count=%0d ovf=%b, required 4 1", sb_count, sb_overflow);
        end
        drain();
        n_cmp++;
        if (sb_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", sb_overflow);
        end
    endtask

    task automatic test_full_concurrent();
        do_reset();
        mem_wready = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
        mem_wready = 1'b1;
        store(32'h300, 32'hB000);
        n_cmp++;
        if (sb_count !== 3'd4 || sb_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovf=%b, required 4 0", sb_count, sb_overflow);
        end
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            store(32'h400 + 32'(4 * i) + 32'(i % 4), 32'hC000 + 32'(i));
            n_cmp++;
            if (sb_count !== 3'(exp_q.size())) begin
                n_fail++;
                $display("FAIL wrap_count: got %0d, required %0d", sb_count, exp_q.size());
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mem_wready = 1'b0;
        store(32'h80, 32'h8080);
        store(32'h84, 32'h8484);
        store(32'h88, 32'h8888);
        n_cmp++;
        if (sb_count !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d, required 3", sb_count);
        end
        mem_wready = 1'b1;
        do_reset();
        n_cmp++;
        if (sb_count !== 3'd0 || mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d wvalid=%b, required 0 0", sb_count, mem_wvalid);
        end
        dmem_addr = 32'h84;
        mem_rdata = 32'h12345678;
        #1;
        n_cmp++;
        if (dmem_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL post_reset_load: got %h, required 12345678", dmem_data);
        end
        cycle();
        mem_wready = 1'b0;
        n_cmp++;
        if (mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: wvalid=%b, required 0", mem_wvalid);
        end
    endtask

    initial begin
        reset          = 1'b1;
        dmem_addr      = '0;
        write_enable   = 1'b0;
        write_mem_data = '0;
        mem_rdata      = '0;
        mem_wready     = 1'b0;
        cycle();
        cycle();
        test_reset();
        test_drain_order();
        test_bypass();
        test_overflow();
        test_full_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
